// File: rtl/alu_pkg.sv
// Shared ALU encodings and the multiply sequencer state type.
package alu_pkg;

  localparam logic [4:0] FS_PASS_A16 = 5'b10000;
  localparam logic [4:0] FS_ADD16    = 5'b10100;
  localparam logic [4:0] FS_LSL16    = 5'b11011;

  // ALU flag register bit positions
  localparam int Z = 3;
  localparam int C = 2;
  localparam int N = 1;
  localparam int O = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Unsigned shift-and-add multiplier that borrows the shared 16-bit ALU,
// one micro-op per cycle, with valid/ready request and response channels.
//
// state | meaning
// IDLE  | ready for operands, ALU not owned
// ADD   | prod + mcand (or pass prod) through ALU depending on mplr[0]
// SHIFT | mcand << 1 through ALU, mplr shifted internally
// DONE  | product held on the response channel until accepted
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_product,
  output logic             rsp_zero,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [4:0]       alu_funsel,
  output logic             alu_wf,
  input  logic [15:0]      alu_out,
  output logic             busy
);

  mul_state_t       state;
  logic [15:0]      prod;
  logic [15:0]      mcand;
  logic [WIDTH-1:0] mplr;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Handshake/busy flags are registered alongside the state they decode.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      prod      <= '0;
      mcand     <= '0;
      mplr      <= '0;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mcand     <= 16'(req_a);
            mplr      <= req_b;
            prod      <= '0;
            cnt       <= '0;
            state     <= ADD;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ADD: begin
          prod  <= alu_out;
          state <= SHIFT;
        end
        SHIFT: begin
          mcand <= alu_out;
          mplr  <= mplr >> 1;
          if (last_iter) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= ADD;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_product = rsp_valid ? prod : 16'h0000;
  assign rsp_zero    = rsp_valid && (prod == 16'h0000);

  // Flags are written only on the final accumulation so they describe the product.
  always_comb begin
    alu_a      = 16'h0000;
    alu_b      = 16'h0000;
    alu_funsel = FS_PASS_A16;
    alu_wf     = 1'b0;
    case (state)
      ADD: begin
        alu_a      = prod;
        alu_b      = mcand;
        alu_funsel = mplr[0] ? FS_ADD16 : FS_PASS_A16;
        alu_wf     = last_iter;
      end
      SHIFT: begin
        alu_a      = mcand;
        alu_funsel = FS_LSL16;
      end
      default: begin
        alu_a      = 16'h0000;
        alu_funsel = FS_PASS_A16;
      end
    endcase
  end

endmodule
